// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with buffered multi-cycle results
// and keeps a busy scoreboard of pending multi-cycle destinations. Optional macro: WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_dest,
  input  logic [31:0] pipe_data,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_dest,
  input  logic [31:0] mc_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_dest,
  output logic [31:0] busy_mask,
  output logic        waw_err,
  output logic        rf_load,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_in
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL_CNT = QDEPTH[AW:0];

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } entry_t;

  entry_t      mem [QDEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  entry_t      head;

  logic        p1_fire;
  logic        push;
  logic        pop;
  logic        bypass;
  logic        fifo_wr;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] busy_next;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign count = wptr - rptr;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rptr[AW-1:0]];

  // Ready depends only on registered state, never on mc_valid.
  assign mc_ready = !full && !rst;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    p1_fire  = pipe_valid && (pipe_dest != 5'd0);
    push     = mc_valid && mc_ready;
`ifdef WB_BYPASS_EN
    bypass   = push && empty && !p1_fire;
`else
    bypass   = 1'b0;
`endif
    fifo_wr  = push && !bypass;
    pop      = !p1_fire && !empty;
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_dest != 5'd0)) begin
      set_mask = 32'd1 << issue_dest;
    end
    if (pop) begin
      clr_mask = 32'd1 << head.dest;
    end else if (bypass) begin
      clr_mask = 32'd1 << mc_dest;
    end
    // Set beats clear when both hit the same register in one cycle.
    busy_next    = (busy_mask & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wptr[AW-1:0]] <= '{dest: mc_dest, data: mc_data};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (fifo_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_load <= 1'b0;
      rf_dest <= '0;
      rf_in   <= '0;
    end else if (p1_fire) begin
      rf_load <= 1'b1;
      rf_dest <= pipe_dest;
      rf_in   <= pipe_data;
    end else if (pop) begin
      rf_load <= (head.dest != 5'd0);
      rf_dest <= head.dest;
      rf_in   <= head.data;
    end else if (bypass) begin
      rf_load <= (mc_dest != 5'd0);
      rf_dest <= mc_dest;
      rf_in   <= mc_data;
    end else begin
      rf_load <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_mask <= '0;
      waw_err   <= 1'b0;
    end else begin
      busy_mask <= busy_next;
      if (p1_fire && busy_mask[pipe_dest]) begin
        waw_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts each cycle's
// outputs; a separate monitor compares them against the DUT.
module tb_regfile_wb_arbiter;

  localparam int QDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_dest = '0;
  logic [31:0] pipe_data = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_dest = '0;
  logic [31:0] mc_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_dest = '0;
  logic [31:0] busy_mask;
  logic        waw_err;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;

  regfile_wb_arbiter #(.QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_dest(pipe_dest), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_dest(mc_dest), .mc_data(mc_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .busy_mask(busy_mask), .waw_err(waw_err),
    .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit          load;
    bit          ready;
    logic [31:0] busy;
    bit          waw;
  } state_t;

  wr_t    model_fifo[$];
  wr_t    exp_wr[$];
  state_t exp_st[$];
  bit     model_busy[32];
  bit     model_waw;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] pack_busy();
    logic [31:0] m = '0;
    for (int r = 0; r < 32; r++) m[r] = model_busy[r];
    return m;
  endfunction

  // One cycle: drive inputs on the negedge and predict what the following posedge produces.
  task automatic step(input bit pv, input logic [4:0] pd, input logic [31:0] pdat,
                      input bit mv, input logic [4:0] md, input logic [31:0] mdat,
                      input bit iv, input logic [4:0] id);
    bit     p1, accepted, load, used_bypass;
    wr_t    w;
    state_t s;
    @(negedge clk);
    pipe_valid = pv; pipe_dest = pd; pipe_data = pdat;
    mc_valid = mv; mc_dest = md; mc_data = mdat;
    issue_valid = iv; issue_dest = id;

    p1 = pv && (pd != 0);
    accepted = mv && (model_fifo.size() < QDEPTH);
    load = 0;
    used_bypass = 0;
    if (p1) begin
      if (model_busy[pd]) model_waw = 1;
      exp_wr.push_back('{dest: pd, data: pdat});
      load = 1;
    end else if (model_fifo.size() > 0) begin
      w = model_fifo.pop_front();
      model_busy[w.dest] = 0;
      if (w.dest != 0) begin
        exp_wr.push_back(w);
        load = 1;
      end
    end
`ifdef WB_BYPASS_EN
    else if (accepted) begin
      used_bypass = 1;
      model_busy[md] = 0;
      if (md != 0) begin
        exp_wr.push_back('{dest: md, data: mdat});
        load = 1;
      end
    end
`endif
    if (accepted && !used_bypass) model_fifo.push_back('{dest: md, data: mdat});
    if (iv && id != 0) model_busy[id] = 1;
    model_busy[0] = 0;

    s.load  = load;
    s.ready = (model_fifo.size() < QDEPTH);
    s.busy  = pack_busy();
    s.waw   = model_waw;
    exp_st.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_model();
    model_fifo.delete();
    for (int r = 0; r < 32; r++) model_busy[r] = 0;
    model_waw = 0;
  endtask

  // Asynchronous reset asserted between edges, checked before and after release.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    pipe_valid = 0; mc_valid = 0; issue_valid = 0;
    reset_model();
    #1;
    check("rst_rf_load", 64'(rf_load), 64'(0));
    check("rst_rf_dest", 64'(rf_dest), 64'(0));
    check("rst_rf_in", 64'(rf_in), 64'(0));
    check("rst_busy", 64'(busy_mask), 64'(0));
    check("rst_waw", 64'(waw_err), 64'(0));
    check("rst_mc_ready", 64'(mc_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_mc_ready", 64'(mc_ready), 64'(1));
    check("post_rst_rf_load", 64'(rf_load), 64'(0));
  endtask

  // Monitor: compares every post-edge cycle against the oldest prediction.
  initial begin
    state_t s;
    wr_t    w;
    forever begin
      @(posedge clk);
      #1;
      if (exp_st.size() > 0) begin
        s = exp_st.pop_front();
        check("mc_ready", 64'(mc_ready), 64'(s.ready));
        check("busy_mask", 64'(busy_mask), 64'(s.busy));
        check("waw_err", 64'(waw_err), 64'(s.waw));
        check("rf_load", 64'(rf_load), 64'(s.load));
        if (s.load && exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          check("rf_dest", 64'(rf_dest), 64'(w.dest));
          check("rf_in", 64'(rf_in), 64'(w.data));
        end
      end
    end
  end

  initial begin
    reset_model();
    #12;
    check("init_rf_load", 64'(rf_load), 64'(0));
    check("init_busy", 64'(busy_mask), 64'(0));
    check("init_mc_ready", 64'(mc_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_release_mc_ready", 64'(mc_ready), 64'(1));
    idle(2);

    // Pipeline-only, including a write to x0.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    idle(1);

    // Priority and ordering: pipeline held 3 cycles while two results are pushed.
    step(1, 1, 32'hA1, 1, 7, 32'h11, 0, 0);
    step(1, 2, 32'hA2, 1, 8, 32'h22, 0, 0);
    step(1, 3, 32'hA3, 0, 0, 0, 0, 0);
    idle(3);

    // Full FIFO under continuous pipeline traffic, then drain.
    for (int i = 0; i < QDEPTH + 2; i++)
      step(1, 5'(10 + i), 32'(i), 1, 5'(20 + i), 32'hF00 + 32'(i), 0, 0);
    idle(QDEPTH + 2);

    // Scoreboard: issue, WAW detection, clear on pop, set winning over clear.
    step(0, 0, 0, 0, 0, 0, 1, 9);
    step(1, 9, 32'h99, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 9, 32'h909, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 1, 9, 32'h919, 0, 0);
    idle(2);

    // Head with dest 0 pops without a write; then a lone push to show its latency.
    step(0, 0, 0, 1, 0, 32'hBAD, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 3, 32'hA5, 0, 0);
    idle(3);

    // Reset mid-operation discards queued entries and busy bits.
    step(1, 4, 32'h4, 1, 12, 32'hC, 1, 12);
    step(1, 4, 32'h4, 1, 13, 32'hD, 1, 13);
    apply_reset();
    idle(3);

    // Randomised traffic with a narrow destination range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom(),
           $urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom(),
           $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)));
    end
    idle(QDEPTH + 3);

    @(posedge clk);
    #2;
    check("pending_states", 64'(exp_st.size()), 64'(0));
    check("pending_writes", 64'(exp_wr.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
